// File: rtl/gtx_link_codec.sv
// 16-bit 8b/10b framing codec: TX inserts K28.5 comma words for alignment,
// RX finds commas, undoes a one-byte lane offset and strips K characters.
module gtx_link_codec #(
    parameter int unsigned INIT_COMMAS  = 16,
    parameter int unsigned COMMA_PERIOD = 256,
    parameter logic [7:0]  K_COMMA      = 8'hBC,
    parameter logic [7:0]  D_IDLE       = 8'h50
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [15:0] tx_data_i,
    output logic        tx_ready_o,
    output logic [15:0] tx_data_o,
    output logic [1:0]  tx_ctrl_o,
    input  logic [15:0] rx_data_i,
    input  logic [1:0]  rx_ctrl_i,
    output logic [15:0] rx_data_o,
    output logic        rx_valid_o,
    output logic        rx_aligned_o
);
    localparam int unsigned PW = (COMMA_PERIOD > 1) ? $clog2(COMMA_PERIOD) : 1;
    localparam logic [15:0] COMMA_WORD = {D_IDLE, K_COMMA};

    typedef enum logic {ST_INIT, ST_RUN} tx_state_t;

    tx_state_t     state, state_nxt;
    logic [15:0]   init_cnt, init_cnt_nxt;
    logic [PW-1:0] per_cnt, per_cnt_nxt;
    logic [15:0]   tx_data_nxt;
    logic [1:0]    tx_ctrl_nxt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= ST_INIT;
            init_cnt  <= '0;
            per_cnt   <= '0;
            tx_data_o <= COMMA_WORD;
            tx_ctrl_o <= 2'b01;
        end else begin
            state     <= state_nxt;
            init_cnt  <= init_cnt_nxt;
            per_cnt   <= per_cnt_nxt;
            tx_data_o <= tx_data_nxt;
            tx_ctrl_o <= tx_ctrl_nxt;
        end
    end

    // Comma word unless a RUN data slot; user data never carries a K flag.
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        per_cnt_nxt  = per_cnt;
        tx_data_nxt  = COMMA_WORD;
        tx_ctrl_nxt  = 2'b01;
        tx_ready_o   = 1'b0;
        case (state)
            ST_INIT: begin
                init_cnt_nxt = init_cnt + 16'd1;
                if (init_cnt == 16'(INIT_COMMAS - 1)) begin
                    state_nxt   = ST_RUN;
                    per_cnt_nxt = PW'(1);
                end
            end
            ST_RUN: begin
                per_cnt_nxt = (per_cnt == PW'(COMMA_PERIOD - 1)) ? '0 : per_cnt + PW'(1);
                if (per_cnt != '0) begin
                    tx_ready_o  = 1'b1;
                    tx_data_nxt = tx_data_i;
                    tx_ctrl_nxt = 2'b00;
                end
            end
            default: ;
        endcase
    end

    logic [7:0]  prev_hi;
    logic        prev_k;
    logic        offset, offset_nxt, aligned;
    logic        det0, det1;
    logic [15:0] word;
    logic [1:0]  kflag;

    always_comb begin
        det0       = (rx_ctrl_i == 2'b01) && (rx_data_i[7:0] == K_COMMA);
        det1       = (rx_ctrl_i == 2'b10) && (rx_data_i[15:8] == K_COMMA);
        offset_nxt = offset;
        if (det0)      offset_nxt = 1'b0;
        else if (det1) offset_nxt = 1'b1;
        if (offset_nxt) begin
            word  = {rx_data_i[7:0], prev_hi};
            kflag = {rx_ctrl_i[0], prev_k};
        end else begin
            word  = rx_data_i;
            kflag = rx_ctrl_i;
        end
    end

    // Gate on the registered aligned flag so the half-word straddling the
    // first comma can never leak out as data.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prev_hi    <= '0;
            prev_k     <= 1'b0;
            offset     <= 1'b0;
            aligned    <= 1'b0;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
        end else begin
            prev_hi    <= rx_data_i[15:8];
            prev_k     <= rx_ctrl_i[1];
            offset     <= offset_nxt;
            aligned    <= aligned | det0 | det1;
            rx_valid_o <= 1'b0;
            if (aligned && kflag == 2'b00) begin
                rx_data_o  <= word;
                rx_valid_o <= 1'b1;
            end
        end
    end

    assign rx_aligned_o = aligned;
endmodule

// File: tb/tb_gtx_link_codec.sv
// Scoreboard bench for gtx_link_codec: stimulus pushes expectations, a
// monitor pops them as the DUT produces TX words and valid RX words.
module tb_gtx_link_codec;
    localparam int INIT = 4;
    localparam int PER  = 8;

    logic        clk = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [15:0] tx_data_i = '0;
    logic        tx_ready_o;
    logic [15:0] tx_data_o;
    logic [1:0]  tx_ctrl_o;
    logic [15:0] rx_data_i;
    logic [1:0]  rx_ctrl_i;
    logic [15:0] rx_data_o;
    logic        rx_valid_o;
    logic        rx_aligned_o;

    gtx_link_codec #(.INIT_COMMAS(INIT), .COMMA_PERIOD(PER)) dut (
        .clk_i(clk), .rst_n_i(rst_n_i),
        .tx_data_i(tx_data_i), .tx_ready_o(tx_ready_o),
        .tx_data_o(tx_data_o), .tx_ctrl_o(tx_ctrl_o),
        .rx_data_i(rx_data_i), .rx_ctrl_i(rx_ctrl_i),
        .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o),
        .rx_aligned_o(rx_aligned_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  ctrl;
        logic        rdy;
    } tx_exp_t;

    tx_exp_t     txq[$];
    logic [15:0] rxq[$];
    int          total = 0;
    int          bad = 0;

    // mode 0: directed rx, 1: loopback aligned, 2: loopback shifted one byte
    int          mode = 0;
    bit          skip = 1'b0;
    bit          rel = 1'b0;
    bit          rnd = 1'b0;
    int          e = 0;
    int          resume_e = -1;
    logic [15:0] txv = 16'h1234;
    logic [15:0] last_acc = '0;
    logic [15:0] rx_dir = '0;
    logic [1:0]  rx_dir_c = 2'b11;
    logic [15:0] tx_prev_d = 16'h50BC;
    logic [1:0]  tx_prev_c = 2'b01;

    always @(posedge clk) begin
        tx_prev_d <= tx_data_o;
        tx_prev_c <= tx_ctrl_o;
    end

    always_comb begin
        rx_data_i = rx_dir;
        rx_ctrl_i = rx_dir_c;
        if (mode == 1) begin
            rx_data_i = tx_data_o;
            rx_ctrl_i = tx_ctrl_o;
        end else if (mode == 2) begin
            rx_data_i = {tx_data_o[7:0], tx_prev_d[15:8]};
            rx_ctrl_i = {tx_ctrl_o[0], tx_prev_c[1]};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        tx_exp_t x;
        logic    rdy_q;
        rdy_q = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (txq.size() > 0) begin
                x = txq.pop_front();
                chk("tx_data", 32'(tx_data_o), 32'(x.data));
                chk("tx_ctrl", 32'(tx_ctrl_o), 32'(x.ctrl));
                chk("tx_ready", 32'(rdy_q), 32'(x.rdy));
            end
            rdy_q = tx_ready_o;
            if (rx_valid_o && !skip) begin
                if (rxq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rx_extra: got %h expected no word", rx_data_o);
                end else begin
                    chk("rx_data", 32'(rx_data_o), 32'(rxq.pop_front()));
                end
            end
        end
    end

    // One cycle of stimulus for the upcoming edge; the comma schedule is
    // derived from the edge count since reset release.
    task automatic cyc(input logic [15:0] rd, input logic [1:0] rc);
        bit      dat;
        tx_exp_t x;
        @(negedge clk);
        if (rel) begin
            rst_n_i = 1'b1;
            rel = 1'b0;
            e = 0;
        end
        e++;
        dat = (e > INIT) && (((e - INIT) % PER) != 0);
        tx_data_i = dat ? txv : (16'hDEAD ^ 16'(e));
        rx_dir = rd;
        rx_dir_c = rc;
        if (skip && e == resume_e) begin
            skip = 1'b0;
            rxq.delete();
            rxq.push_back(last_acc);
        end
        if (skip && resume_e < 0 && e > INIT && !dat) resume_e = e + 2;
        if (dat && mode != 0 && !skip) rxq.push_back(txv);
        x.data = dat ? txv : 16'h50BC;
        x.ctrl = dat ? 2'b00 : 2'b01;
        x.rdy  = dat;
        txq.push_back(x);
        if (dat) begin
            last_acc = txv;
            txv = rnd ? 16'($urandom) : txv + 16'd1;
        end
    endtask

    task automatic idle();
        cyc(16'h0000, 2'b11);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n_i = 1'b0;
        #1;
        txq.delete();
        rxq.delete();
        skip = 1'b0;
        resume_e = -1;
        chk("rst_tx_data", 32'(tx_data_o), 32'h50BC);
        chk("rst_tx_ctrl", 32'(tx_ctrl_o), 32'h1);
        chk("rst_tx_ready", 32'(tx_ready_o), 32'h0);
        chk("rst_rx_data", 32'(rx_data_o), 32'h0);
        chk("rst_rx_valid", 32'(rx_valid_o), 32'h0);
        chk("rst_rx_aligned", 32'(rx_aligned_o), 32'h0);
        repeat (2) @(negedge clk);
        rel = 1'b1;
    endtask

    initial begin
        do_reset();
        // init commas, then incrementing data with a comma every PER edges
        repeat (28) idle();
        chk("rx_aligned_pre", 32'(rx_aligned_o), 32'h0);

        cyc(16'h50BC, 2'b01);
        rxq.push_back(16'hA5A5);
        cyc(16'hA5A5, 2'b00);
        chk("rx_aligned_post", 32'(rx_aligned_o), 32'h1);
        idle();

        rxq.push_back(16'h1234);
        rxq.push_back(16'h5678);
        cyc(16'hBC00, 2'b10);
        cyc(16'h3450, 2'b00);
        cyc(16'h7812, 2'b00);
        cyc(16'h0056, 2'b00);

        // non-comma K byte keeps offset 1
        rxq.push_back(16'hAB00);
        rxq.push_back(16'hEFCD);
        cyc(16'h00F7, 2'b01);
        cyc(16'hCDAB, 2'b00);
        cyc(16'h00EF, 2'b00);
        repeat (3) idle();
        chk("rx_directed_drain", 32'(rxq.size()), 32'h0);

        do_reset();
        mode = 1;
        rnd = 1'b1;
        repeat (40) idle();

        mode = 2;
        skip = 1'b1;
        resume_e = -1;
        repeat (30) idle();

        do_reset();
        repeat (40) idle();

        repeat (3) @(posedge clk);
        #2;
        skip = 1'b1;
        chk("rx_final_drain", 32'(rxq.size()), 32'h0);
        chk("tx_final_drain", 32'(txq.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
